// File: rtl/kp_host_ctrl_pkg.sv
// Shared types and constants for the K-Port host controller.
package kp_host_ctrl_pkg;

    localparam int KP_BITS  = 32;
    localparam int KP_BIT_W = $clog2(KP_BITS);
    localparam int KP_PORTS = 2;

    localparam logic KP_REG_CTRL = 1'b0;
    localparam logic KP_REG_DATA = 1'b1;

    typedef enum logic [2:0] {
        KP_IDLE,
        KP_LATCH,
        KP_LOW,
        KP_HIGH,
        KP_DONE
    } kp_state_e;

    typedef struct packed {
        logic irq_en;
        logic mode;
        logic start;
    } kp_ctrl_t;

    // Split the low CTRL bits of a bus write into named fields.
    function automatic kp_ctrl_t kp_decode_ctrl(input logic [2:0] di);
        kp_ctrl_t c;
        c.irq_en = di[2];
        c.mode   = di[1];
        c.start  = di[0];
        return c;
    endfunction

    // Status word as seen on a STAT read.
    function automatic logic [KP_BITS-1:0] kp_stat_word(input logic irq_en,
                                                        input logic done,
                                                        input logic busy);
        return {{(KP_BITS-3){1'b0}}, irq_en, done, busy};
    endfunction

endpackage

// File: rtl/kp_port_seq.sv
// One K-Port sequencer: transfer FSM, phase/bit counters, data word and KP_DIN
// synchronizer. Wire outputs are registered from the next state so they never
// glitch across state-encoding changes, and still drop at once on async reset.
module kp_port_seq
    import kp_host_ctrl_pkg::*;
#(
    parameter int LATCH_CYC = 4,
    parameter int DIV       = 4
) (
    input  logic               CLK,
    input  logic               RES,
    input  logic               ctrl_wr,
    input  logic               ctrl_start,
    input  logic               ctrl_mode,
    input  logic               ctrl_irq_en,
    input  logic               data_wr,
    input  logic [KP_BITS-1:0] data_wdata,
    input  logic               data_rd,
    input  logic               kp_din,
    output logic               busy,
    output logic               done,
    output logic               irq_en,
    output logic [KP_BITS-1:0] data,
    output logic               kp_latch,
    output logic               kp_clk,
    output logic               kp_rw,
    output logic               kp_dout
);

    localparam int PH_MAX = (LATCH_CYC > DIV) ? LATCH_CYC : DIV;
    localparam int PH_W   = $clog2(PH_MAX);

    localparam logic [PH_W-1:0]     PH_LATCH_END = PH_W'(LATCH_CYC - 1);
    localparam logic [PH_W-1:0]     PH_DIV_END   = PH_W'(DIV - 1);
    localparam logic [KP_BIT_W-1:0] BIT_LAST     = KP_BIT_W'(KP_BITS - 1);

    kp_state_e           state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [KP_BIT_W-1:0] bit_q, bit_d;
    logic                mode_q, mode_d;
    logic                start_ok;
    logic                sample_en;
    logic                xfer_d;
    logic                shift_d;
    logic                done_q;
    logic                irq_en_q;
    logic [KP_BITS-1:0]  data_q;
    logic                din_sync_p0, din_sync_p1;
    logic                kp_latch_q, kp_clk_q, kp_rw_q, kp_dout_q;

    assign busy = (state_q == KP_LATCH) || (state_q == KP_LOW) || (state_q == KP_HIGH);

    // Next-state logic: walk LATCH, then 32 LOW/HIGH pairs, then one DONE cycle.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        start_ok = 1'b0;
        unique case (state_q)
            KP_IDLE, KP_DONE: begin
                state_d = KP_IDLE;
                if (ctrl_wr && ctrl_start) begin
                    state_d  = KP_LATCH;
                    phase_d  = '0;
                    bit_d    = '0;
                    start_ok = 1'b1;
                end
            end
            KP_LATCH: begin
                if (phase_q == PH_LATCH_END) begin
                    state_d = KP_LOW;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            KP_LOW: begin
                if (phase_q == PH_DIV_END) begin
                    state_d = KP_HIGH;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            KP_HIGH: begin
                if (phase_q == PH_DIV_END) begin
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = KP_DONE;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = KP_LOW;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = KP_IDLE;
        endcase
    end

    // Direction may only change between transfers.
    always_comb begin
        mode_d = mode_q;
        if (ctrl_wr && !busy) begin
            mode_d = ctrl_mode;
        end
    end

    // Last LOW cycle: the synchronizer output is from two cycles earlier, still
    // well after the device finished updating from the previous rising edge.
    assign sample_en = (state_q == KP_LOW) && (phase_q == PH_DIV_END) && !mode_q;
    assign xfer_d    = (state_d == KP_LATCH) || (state_d == KP_LOW) || (state_d == KP_HIGH);
    assign shift_d   = (state_d == KP_LOW) || (state_d == KP_HIGH);

    // Sequencer control registers.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q  <= KP_IDLE;
            phase_q  <= '0;
            bit_q    <= '0;
            mode_q   <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            mode_q  <= mode_d;
            if (ctrl_wr) begin
                irq_en_q <= ctrl_irq_en;
            end
            // A new start clears done; completion beats a same-cycle DATA read.
            if (start_ok) begin
                done_q <= 1'b0;
            end else if (state_q == KP_DONE) begin
                done_q <= 1'b1;
            end else if (data_rd) begin
                done_q <= 1'b0;
            end
        end
    end

    // Data word: CPU load while idle, LSB-first assembly of the inverted wire in read mode.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            data_q <= '0;
        end else if (data_wr && !busy) begin
            data_q <= data_wdata;
        end else if (sample_en) begin
            data_q[bit_q] <= ~din_sync_p1;
        end
    end

    // Two-flop synchronizer for KP_DIN; idle wire level is high.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            din_sync_p0 <= 1'b1;
            din_sync_p1 <= 1'b1;
        end else begin
            din_sync_p0 <= kp_din;
            din_sync_p1 <= din_sync_p0;
        end
    end

    // Wire outputs registered from the next state so they line up with state_q.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            kp_latch_q <= 1'b0;
            kp_clk_q   <= 1'b0;
            kp_rw_q    <= 1'b0;
            kp_dout_q  <= 1'b0;
        end else begin
            kp_latch_q <= (state_d == KP_LATCH);
            kp_clk_q   <= (state_d == KP_HIGH);
            kp_rw_q    <= mode_d && xfer_d;
            kp_dout_q  <= mode_d && shift_d && data_q[bit_d];
        end
    end

    assign done     = done_q;
    assign irq_en   = irq_en_q;
    assign data     = data_q;
    assign kp_latch = kp_latch_q;
    assign kp_clk   = kp_clk_q;
    assign kp_rw    = kp_rw_q;
    assign kp_dout  = kp_dout_q;

endmodule

// File: rtl/kp_host_ctrl.sv
// K-Port host controller top: CPU register decode, read-data register, IRQ,
// and one kp_port_seq per port.
module kp_host_ctrl
    import kp_host_ctrl_pkg::*;
#(
    parameter int LATCH_CYC = 4,
    parameter int DIV       = 4
) (
    input  logic                CLK,
    input  logic                RES,
    input  logic                CE,
    input  logic                WR,
    input  logic [1:0]          ADDR,
    input  logic [KP_BITS-1:0]  DI,
    output logic [KP_BITS-1:0]  DO,
    output logic                IRQ,
    output logic [KP_PORTS-1:0] KP_LATCH,
    output logic [KP_PORTS-1:0] KP_CLK,
    output logic [KP_PORTS-1:0] KP_RW,
    output logic [KP_PORTS-1:0] KP_DOUT,
    input  logic [KP_PORTS-1:0] KP_DIN
);

    logic [KP_PORTS-1:0] busy;
    logic [KP_PORTS-1:0] done;
    logic [KP_PORTS-1:0] irq_en;
    logic [KP_PORTS-1:0] ctrl_wr;
    logic [KP_PORTS-1:0] data_wr;
    logic [KP_PORTS-1:0] data_rd;
    logic [KP_BITS-1:0]  data [KP_PORTS];
    kp_ctrl_t            ctrl;
    logic                sel_port;
    logic                sel_reg;
    logic [KP_BITS-1:0]  do_p1;

    assign ctrl     = kp_decode_ctrl(DI[2:0]);
    assign sel_port = ADDR[1];
    assign sel_reg  = ADDR[0];

    // Route the single bus access to one port's CTRL or DATA register.
    always_comb begin
        ctrl_wr = '0;
        data_wr = '0;
        data_rd = '0;
        if (CE) begin
            if (WR && (sel_reg == KP_REG_CTRL)) begin
                ctrl_wr[sel_port] = 1'b1;
            end
            if (WR && (sel_reg == KP_REG_DATA)) begin
                data_wr[sel_port] = 1'b1;
            end
            if (!WR && (sel_reg == KP_REG_DATA)) begin
                data_rd[sel_port] = 1'b1;
            end
        end
    end

    for (genvar p = 0; p < KP_PORTS; p++) begin : g_port
        kp_port_seq #(
            .LATCH_CYC (LATCH_CYC),
            .DIV       (DIV)
        ) u_seq (
            .CLK         (CLK),
            .RES         (RES),
            .ctrl_wr     (ctrl_wr[p]),
            .ctrl_start  (ctrl.start),
            .ctrl_mode   (ctrl.mode),
            .ctrl_irq_en (ctrl.irq_en),
            .data_wr     (data_wr[p]),
            .data_wdata  (DI),
            .data_rd     (data_rd[p]),
            .kp_din      (KP_DIN[p]),
            .busy        (busy[p]),
            .done        (done[p]),
            .irq_en      (irq_en[p]),
            .data        (data[p]),
            .kp_latch    (KP_LATCH[p]),
            .kp_clk      (KP_CLK[p]),
            .kp_rw       (KP_RW[p]),
            .kp_dout     (KP_DOUT[p])
        );
    end

    // Read data register: captured on a read strobe, held until the next read.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            do_p1 <= '0;
        end else if (CE && !WR) begin
            if (sel_reg == KP_REG_CTRL) begin
                do_p1 <= kp_stat_word(irq_en[sel_port], done[sel_port], busy[sel_port]);
            end else begin
                do_p1 <= data[sel_port];
            end
        end
    end

    assign DO  = do_p1;
    assign IRQ = |(done & irq_en);

endmodule

// File: tb/tb_kp_host_ctrl.sv
// Bench for kp_host_ctrl: joypad device model on both ports, directed and
// randomized transfers checked against a word-level reference.
module tb_kp_host_ctrl;

    localparam int LATCH_CYC = 4;
    localparam int DIV       = 4;
    localparam int BUSY_LEN  = LATCH_CYC + 64 * DIV;
    localparam int BTN_B1    = 0;
    localparam int BTN_RUN   = 7;
    localparam int BTN_U     = 8;

    logic        CLK = 1'b0;
    logic        RES;
    logic        CE;
    logic        WR;
    logic [1:0]  ADDR;
    logic [31:0] DI;
    logic [31:0] DO;
    logic        IRQ;
    logic [1:0]  KP_LATCH, KP_CLK, KP_RW, KP_DOUT, KP_DIN;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    kp_host_ctrl #(.LATCH_CYC(LATCH_CYC), .DIV(DIV)) dut (
        .CLK      (CLK),
        .RES      (RES),
        .CE       (CE),
        .WR       (WR),
        .ADDR     (ADDR),
        .DI       (DI),
        .DO       (DO),
        .IRQ      (IRQ),
        .KP_LATCH (KP_LATCH),
        .KP_CLK   (KP_CLK),
        .KP_RW    (KP_RW),
        .KP_DOUT  (KP_DOUT),
        .KP_DIN   (KP_DIN)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Joypad device: loads its word while latched, advances two cycles after each rising KP_CLK.
    logic [31:0] dev_word [2];
    logic [31:0] dev_sh   [2];
    logic [1:0]  dev_c1, dev_c2;

    always @(posedge CLK or posedge RES) begin
        if (RES) begin
            dev_sh[0] <= '0;
            dev_sh[1] <= '0;
            dev_c1    <= '0;
            dev_c2    <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                dev_c1[p] <= KP_CLK[p];
                dev_c2[p] <= dev_c1[p];
                if (KP_LATCH[p]) dev_sh[p] <= dev_word[p];
                else if (dev_c1[p] && !dev_c2[p]) dev_sh[p] <= {1'b0, dev_sh[p][31:1]};
            end
        end
    end

    assign KP_DIN = ~{dev_sh[1][0], dev_sh[0][0]};

    // Wire monitor: rising-edge history of KP_DOUT/KP_RW, last falling edge, activity count.
    int edge_cnt  [2];
    int nz_cnt    [2];
    int last_fall [2];
    bit dout_hist [2][1024];
    bit rw_hist   [2][1024];
    bit [1:0] clk_prev;

    always @(posedge CLK) begin
        for (int p = 0; p < 2; p++) begin
            if (KP_CLK[p] && !clk_prev[p]) begin
                dout_hist[p][edge_cnt[p] & 1023] <= KP_DOUT[p];
                rw_hist[p][edge_cnt[p] & 1023]   <= KP_RW[p];
                edge_cnt[p] <= edge_cnt[p] + 1;
            end
            if (!KP_CLK[p] && clk_prev[p]) last_fall[p] <= cyc;
            if (KP_LATCH[p] || KP_CLK[p] || KP_RW[p] || KP_DOUT[p]) nz_cnt[p] <= nz_cnt[p] + 1;
            clk_prev[p] <= KP_CLK[p];
        end
    end

    // Reference: a joypad word is a fixed 4'hF signature above 12 active-high button bits.
    function automatic logic [31:0] jp_word(input logic [11:0] btn);
        return {4'hF, 16'h0000, btn};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge CLK);
        CE = 1'b1; WR = 1'b1; ADDR = a; DI = d;
        @(negedge CLK);
        CE = 1'b0; WR = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge CLK);
        CE = 1'b1; WR = 1'b0; ADDR = a;
        @(negedge CLK);
        CE = 1'b0;
        d = DO;
    endtask

    task automatic wait_idle(input logic [1:0] a, input string tag);
        logic [31:0] s;
        int n;
        s = 32'd1;
        n = 0;
        while (s[0] && n < 400) begin
            bus_rd(a, s);
            n++;
        end
        check(tag, {31'b0, s[0]}, 32'd0);
    endtask

    // Poll STAT every cycle from the current negedge; sample k of DO/IRQ describes
    // the register state k cycles after the previous rising edge.
    task automatic run_measure(input logic [1:0] a, output int busy_cyc,
                               output int done_gap, output int irq_gap);
        bit b [300];
        bit d [300];
        bit q [301];
        int fall, fd, fi;
        q[0] = IRQ;
        CE = 1'b1; WR = 1'b0; ADDR = a;
        for (int j = 0; j < 300; j++) begin
            @(negedge CLK);
            b[j]   = DO[0];
            d[j]   = DO[1];
            q[j+1] = IRQ;
        end
        CE = 1'b0;
        busy_cyc = 0; fall = -1; fd = -1; fi = -1;
        for (int j = 0; j < 300; j++) begin
            if (b[j]) busy_cyc++;
            if (fall < 0 && j > 0 && b[j-1] && !b[j]) fall = j;
            if (fall >= 0 && fd < 0 && d[j]) fd = j;
            if (fall >= 0 && fi < 0 && q[j]) fi = j;
        end
        done_gap = (fall >= 0 && fd >= 0) ? fd - fall : -1;
        irq_gap  = (fall >= 0 && fi >= 0) ? fi - fall : -1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, w, wdat, exp0, exp1;
        logic [11:0] btn;
        logic        pp;
        int bc, dg, ig, e0, e1, nz0, rwn, n;

        RES = 1'b1; CE = 1'b0; WR = 1'b0; ADDR = 2'b00; DI = '0;
        dev_word[0] = jp_word(12'h000);
        dev_word[1] = jp_word(12'h000);
        repeat (3) @(negedge CLK);
        check("rst_kp_outputs", {24'b0, KP_LATCH, KP_CLK, KP_RW, KP_DOUT}, 32'd0);
        check("rst_do", DO, 32'd0);
        check("rst_irq", {31'b0, IRQ}, 32'd0);
        RES = 1'b0;
        bus_rd(2'b00, r); check("rst_stat0", r, 32'd0);
        bus_rd(2'b10, r); check("rst_stat1", r, 32'd0);
        bus_rd(2'b01, r); check("rst_data0", r, 32'd0);

        // Port 0 read with b1, run, up pressed.
        btn = '0;
        btn[BTN_B1] = 1'b1; btn[BTN_RUN] = 1'b1; btn[BTN_U] = 1'b1;
        dev_word[0] = jp_word(btn);
        bus_wr(2'b00, 32'h1);
        run_measure(2'b00, bc, dg, ig);
        check("p0_busy_len", 32'(bc), 32'(BUSY_LEN));
        check("p0_done_gap", 32'(dg), 32'd1);
        bus_rd(2'b00, r); check("p0_stat_done", r, 32'h2);
        bus_rd(2'b01, r); check("p0_data", r, 32'hF000_0181);
        bus_rd(2'b00, r); check("p0_stat_clr", r, 32'h0);

        // Port 1 read, no buttons; port 0 must stay quiet.
        dev_word[1] = jp_word(12'h000);
        nz0 = nz_cnt[0];
        bus_wr(2'b10, 32'h1);
        wait_idle(2'b10, "p1_idle_wait");
        bus_rd(2'b11, r); check("p1_data_none", r, 32'hF000_0000);
        check("p0_quiet", 32'(nz_cnt[0] - nz0), 32'd0);

        // Randomized reads on either port.
        for (int i = 0; i < 3; i++) begin
            pp  = 1'($urandom_range(0, 1));
            btn = 12'($urandom);
            dev_word[pp] = jp_word(btn);
            bus_wr({pp, 1'b0}, 32'h1);
            wait_idle({pp, 1'b0}, "rnd_idle_wait");
            bus_rd({pp, 1'b1}, r);
            check("rnd_read_data", r, jp_word(btn));
        end

        // Write mode: serial stream LSB first, RW high, exactly 32 edges, data kept.
        for (int i = 0; i < 2; i++) begin
            wdat = (i == 0) ? 32'hA5A5_5A5A : $urandom;
            bus_wr(2'b01, wdat);
            e0 = edge_cnt[0];
            bus_wr(2'b00, 32'h3);
            run_measure(2'b00, bc, dg, ig);
            check("wr_edges", 32'(edge_cnt[0] - e0), 32'd32);
            w = '0; rwn = 0;
            for (int k = 0; k < 32; k++) begin
                w[k] = dout_hist[0][(e0 + k) & 1023];
                rwn += int'(rw_hist[0][(e0 + k) & 1023]);
            end
            check("wr_stream", w, wdat);
            check("wr_rw_high", 32'(rwn), 32'd32);
            check("wr_rw_after", {31'b0, KP_RW[0]}, 32'd0);
            bus_rd(2'b01, r); check("wr_data_kept", r, wdat);
        end

        // IRQ timing, ignored second start (also tries to switch to write mode).
        btn = 12'($urandom);
        dev_word[1] = jp_word(btn);
        e1 = edge_cnt[1];
        bus_wr(2'b10, 32'h5);
        repeat (40) @(negedge CLK);
        bus_wr(2'b10, 32'h7);
        run_measure(2'b10, bc, dg, ig);
        check("irq_gap", 32'(ig), 32'd1);
        check("irq_edges", 32'(edge_cnt[1] - e1), 32'd32);
        rwn = 0;
        for (int k = 0; k < 32; k++) rwn += int'(rw_hist[1][(e1 + k) & 1023]);
        check("irq_mode_kept", 32'(rwn), 32'd0);
        check("irq_high", {31'b0, IRQ}, 32'd1);
        bus_rd(2'b11, r);
        check("irq_data", r, jp_word(btn));
        check("irq_cleared", {31'b0, IRQ}, 32'd0);
        bus_rd(2'b10, r); check("irq_stat", r, 32'h4);

        // Reset in the middle of bit 17 of a write transfer.
        wdat = $urandom | 32'h0002_0000;
        bus_wr(2'b01, wdat);
        e0 = edge_cnt[0];
        bus_wr(2'b00, 32'h3);
        n = 0;
        while (edge_cnt[0] < e0 + 18 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("rst_mid_reached", {31'b0, edge_cnt[0] >= e0 + 18}, 32'd1);
        check("rst_mid_before", {29'b0, KP_CLK[0], KP_RW[0], KP_DOUT[0]}, 32'h7);
        #2 RES = 1'b1;
        #1 check("rst_mid_outputs", {24'b0, KP_LATCH, KP_CLK, KP_RW, KP_DOUT}, 32'd0);
        @(negedge CLK);
        RES = 1'b0;
        bus_rd(2'b00, r); check("rst_mid_stat", r, 32'd0);
        bus_rd(2'b01, r); check("rst_mid_data", r, 32'd0);

        // Concurrent reads on both ports, starts one cycle apart.
        exp0 = jp_word(12'($urandom));
        exp1 = jp_word(12'($urandom));
        dev_word[0] = exp0;
        dev_word[1] = exp1;
        @(negedge CLK);
        CE = 1'b1; WR = 1'b1; ADDR = 2'b00; DI = 32'h1;
        @(negedge CLK);
        ADDR = 2'b10;
        @(negedge CLK);
        CE = 1'b0; WR = 1'b0;
        repeat (280) @(negedge CLK);
        wait_idle(2'b00, "cc_idle0");
        wait_idle(2'b10, "cc_idle1");
        bus_rd(2'b01, r); check("cc_data0", r, exp0);
        bus_rd(2'b11, r); check("cc_data1", r, exp1);
        check("cc_done_skew", 32'(last_fall[1] - last_fall[0]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
